// File: rtl/s2p_pkg.sv
// Shared types and constants for the serial2parallel deserializer and its sync detector.
package s2p_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } s2p_state_e;

   localparam logic [7:0] S2P_SYNC_WORD_DEF = 8'hE4;

endpackage

// File: rtl/sync_detector.sv
// SYNC_LEN-bit history of the sampled serial stream; match_o pulses on a sampled bit
// that completes SYNC_WORD (MSB received first).
module sync_detector
   import s2p_pkg::*;
#(
   parameter int unsigned         SYNC_LEN  = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(S2P_SYNC_WORD_DEF)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic bit_en_i,
   input  logic bit_i,
   output logic match_o
);

   logic [SYNC_LEN-1:0] hist_q;
   logic [SYNC_LEN-1:0] hist_d;

   assign hist_d  = {hist_q[SYNC_LEN-2:0], bit_i};
   // Compare against the history including the bit being sampled, so the FSM can act on the same edge.
   assign match_o = bit_en_i && (hist_d == SYNC_WORD);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist_q <= '0;
      end else if (bit_en_i) begin
         hist_q <= hist_d;
      end
   end

endmodule

// File: rtl/serial2parallel.sv
// MSB-first serial-to-parallel deserializer. Define S2P_FRAME_SYNC_EN to build the
// HUNT/DATA/CHECK frame-sync FSM; otherwise words align to reset release.
module serial2parallel
   import s2p_pkg::*;
#(
   parameter int unsigned         WIDTH       = 2,
   parameter int unsigned         SYNC_LEN    = 8,
   parameter logic [SYNC_LEN-1:0] SYNC_WORD   = SYNC_LEN'(S2P_SYNC_WORD_DEF),
   parameter int unsigned         FRAME_WORDS = 16,
   parameter int unsigned         MISS_MAX    = 2
) (
   input  logic             clk_sig,
   input  logic             reset_sig,
   input  logic             bit_en,
   input  logic             serial_sig,
   output logic [WIDTH-1:0] parallel_sig,
   output logic             parallel_valid,
   output logic             locked,
   output s2p_state_e       dbg_state_o
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-2:0] shift_q, shift_d;
   logic [WIDTH-1:0] par_q, par_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] word_w;
   logic             cnt_last;
   logic             data_bit;
   logic             cnt_clr;

   assign word_w   = {shift_q, serial_sig};
   assign cnt_last = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      par_d   = par_q;
      valid_d = 1'b0;
      if (bit_en) begin
         shift_d = word_w[WIDTH-2:0];
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (data_bit) begin
         cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
      end
      if (data_bit && cnt_last) begin
         par_d   = word_w;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk_sig) begin
      if (reset_sig) begin
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         valid_q <= valid_d;
      end
   end

   assign parallel_sig   = par_q;
   assign parallel_valid = valid_q;

`ifdef S2P_FRAME_SYNC_EN
   localparam int unsigned WCW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam int unsigned SCW = $clog2(SYNC_LEN);
   localparam int unsigned MCW = $clog2(MISS_MAX + 1);

   s2p_state_e     state_q, state_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [SCW-1:0] scnt_q, scnt_d;
   logic [MCW-1:0] miss_q, miss_d;
   logic           sync_match;

   sync_detector #(
      .SYNC_LEN  (SYNC_LEN),
      .SYNC_WORD (SYNC_WORD)
   ) u_sync (
      .clk_i    (clk_sig),
      .rst_i    (reset_sig),
      .bit_en_i (bit_en),
      .bit_i    (serial_sig),
      .match_o  (sync_match)
   );

   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      scnt_d   = scnt_q;
      miss_d   = miss_q;
      data_bit = 1'b0;
      cnt_clr  = 1'b0;
      case (state_q)
         HUNT: begin
            if (sync_match) begin
               state_d = DATA;
               wcnt_d  = '0;
               cnt_clr = 1'b1;
            end
         end
         DATA: begin
            // Sync patterns inside the payload are deliberately not looked at here.
            data_bit = bit_en;
            if (bit_en && cnt_last) begin
               if (wcnt_q == WCW'(FRAME_WORDS - 1)) begin
                  wcnt_d  = '0;
                  scnt_d  = '0;
                  state_d = CHECK;
               end else begin
                  wcnt_d = wcnt_q + WCW'(1);
               end
            end
         end
         CHECK: begin
            if (bit_en) begin
               if (scnt_q == SCW'(SYNC_LEN - 1)) begin
                  scnt_d  = '0;
                  wcnt_d  = '0;
                  cnt_clr = 1'b1;
                  if (sync_match) begin
                     miss_d  = '0;
                     state_d = DATA;
                  end else if (32'(miss_q) + 32'd1 < MISS_MAX) begin
                     miss_d  = miss_q + MCW'(1);
                     state_d = DATA;
                  end else begin
                     miss_d  = '0;
                     state_d = HUNT;
                  end
               end else begin
                  scnt_d = scnt_q + SCW'(1);
               end
            end
         end
         default: state_d = HUNT;
      endcase
   end

   always_ff @(posedge clk_sig) begin
      if (reset_sig) begin
         state_q <= HUNT;
         wcnt_q  <= '0;
         scnt_q  <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         scnt_q  <= scnt_d;
         miss_q  <= miss_d;
      end
   end

   assign locked      = (state_q != HUNT);
   assign dbg_state_o = state_q;
`else
   logic locked_q;
   logic unused_cfg;

   // Free-running alignment: every WIDTH sampled bits after reset release form a word.
   assign data_bit = bit_en;
   assign cnt_clr  = 1'b0;

   always_ff @(posedge clk_sig) begin
      if (reset_sig) begin
         locked_q <= 1'b0;
      end else begin
         locked_q <= 1'b1;
      end
   end

   assign locked      = locked_q;
   assign dbg_state_o = locked_q ? DATA : HUNT;
   assign unused_cfg  = ^{SYNC_WORD, SYNC_LEN[0], FRAME_WORDS[0], MISS_MAX[0]};
`endif

endmodule

// File: tb/tb_serial2parallel.sv
// Directed bench for serial2parallel: free-running build by default, frame-sync
// scenarios when S2P_FRAME_SYNC_EN is defined.
module tb_serial2parallel;
   import s2p_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       en2, ser2, en4, ser4;
   logic [1:0] par2;
   logic       val2, lock2;
   s2p_state_e st2;
   logic [3:0] par4;
   logic       val4, lock4;
   s2p_state_e st4;

   int n_tests = 0;
   int n_fail  = 0;
   logic [1:0] exp_q[$];

   serial2parallel #(.WIDTH(2)) u_dut2 (
      .clk_sig        (clk),
      .reset_sig      (rst),
      .bit_en         (en2),
      .serial_sig     (ser2),
      .parallel_sig   (par2),
      .parallel_valid (val2),
      .locked         (lock2),
      .dbg_state_o    (st2)
   );

   serial2parallel #(.WIDTH(4)) u_dut4 (
      .clk_sig        (clk),
      .reset_sig      (rst),
      .bit_en         (en4),
      .serial_sig     (ser4),
      .parallel_sig   (par4),
      .parallel_valid (val4),
      .locked         (lock4),
      .dbg_state_o    (st4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst  = 1'b1;
      en2  = 1'b0;
      ser2 = 1'b0;
      en4  = 1'b0;
      ser4 = 1'b0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   // Send one bit to the WIDTH=2 instance and score any word it produces.
   task automatic send2(input logic b);
      en2  = 1'b1;
      ser2 = b;
      step();
      if (val2) begin
         if (exp_q.size() == 0) check("spurious_valid", {31'd0, val2}, 32'd0);
         else                   check("word", {30'd0, par2}, {30'd0, exp_q.pop_front()});
      end
   endtask

`ifdef S2P_FRAME_SYNC_EN
   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send2(v[i]);
   endtask

   task automatic send_frame();
      for (int w = 0; w < 16; w++) exp_q.push_back(2'b01);
      for (int w = 0; w < 16; w++) begin
         send2(1'b0);
         send2(1'b1);
      end
      check("frame_all_words", 32'(exp_q.size()), 32'd0);
   endtask
`endif

   logic [3:0] t1_bits = 4'b1001;
   logic [3:0] t1_val  = 4'b0101;
   logic [1:0] t1_par [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
   logic [1:0] t2_tx  [3] = '{2'b11, 2'b01, 2'b10};
   logic [3:0] t3_bits = 4'b1011;
   logic [2:0] junk    = 3'b010;

   initial begin
      rst  = 1'b1;
      en2  = 1'b1;
      ser2 = 1'b1;
      en4  = 1'b1;
      ser4 = 1'b1;
      repeat (2) step();
      check("rst_par2",    {30'd0, par2}, 32'd0);
      check("rst_valid2",  {31'd0, val2}, 32'd0);
      check("rst_locked2", {31'd0, lock2}, 32'd0);
      check("rst_par4",    {28'd0, par4}, 32'd0);
      check("rst_locked4", {31'd0, lock4}, 32'd0);
      do_reset(1);

`ifdef S2P_FRAME_SYNC_EN
      // T4: junk, sync word, one full frame, then a good sync in CHECK
      for (int i = 2; i >= 0; i--) begin
         send2(junk[i]);
         check("t4_hunt_locked", {31'd0, lock2}, 32'd0);
      end
      for (int i = 7; i >= 0; i--) begin
         send2(S2P_SYNC_WORD_DEF[i]);
         check("t4_sync_locked", {31'd0, lock2}, {31'd0, (i == 0)});
      end
      check("t4_state_data", 32'(st2), 32'(DATA));
      send_frame();
      check("t4_state_check", 32'(st2), 32'(CHECK));
      send_byte(8'hE4);
      check("t4_resync_state", 32'(st2), 32'(DATA));
      check("t4_resync_locked", {31'd0, lock2}, 32'd1);

      // T5: two consecutive corrupted sync words drop lock; E4 relocks
      send_frame();
      send_byte(8'h00);
      check("t5_miss1_state", 32'(st2), 32'(DATA));
      check("t5_miss1_locked", {31'd0, lock2}, 32'd1);
      send_frame();
      send_byte(8'h00);
      check("t5_miss2_state", 32'(st2), 32'(HUNT));
      check("t5_miss2_locked", {31'd0, lock2}, 32'd0);
      send_byte(8'hE4);
      check("t5_relock_locked", {31'd0, lock2}, 32'd1);
      check("t5_relock_state", 32'(st2), 32'(DATA));
      send_frame();
`else
      // T1: bits 1,0,0,1 -> 2'b10 then 2'b01 on cycles 2 and 4
      for (int i = 0; i < 4; i++) begin
         en2  = 1'b1;
         ser2 = t1_bits[3-i];
         step();
         check("t1_valid", {31'd0, val2}, {31'd0, t1_val[3-i]});
         check("t1_par", {30'd0, par2}, {30'd0, t1_par[i]});
         check("t1_locked", {31'd0, lock2}, 32'd1);
      end

      // T2: behavioural TX serializer feeding the deserializer, reset together
      do_reset(1);
      for (int w = 0; w < 3; w++) exp_q.push_back(t2_tx[w]);
      for (int w = 0; w < 3; w++) begin
         for (int b = 1; b >= 0; b--) begin
            send2(t2_tx[w][b]);
            check("t2_strobe", {31'd0, val2}, {31'd0, (b == 0)});
         end
      end
      en2 = 1'b0;
      step();
      check("t2_idle_valid", {31'd0, val2}, 32'd0);
      check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // T3: WIDTH=4 with bit_en toggling; disabled cycles carry random junk
      begin
         int k;
         k = 3;
         for (int i = 0; i < 7; i++) begin
            en4 = (i % 2 == 0);
            if (en4) begin
               ser4 = t3_bits[k];
               k--;
            end else begin
               ser4 = 1'($urandom_range(0, 1));
            end
            step();
            check("t3_valid", {31'd0, val4}, {31'd0, (i == 6)});
         end
      end
      check("t3_par", {28'd0, par4}, 32'hB);
      en4 = 1'b0;
      step();
      check("t3_hold_par", {28'd0, par4}, 32'hB);
      check("t3_hold_valid", {31'd0, val4}, 32'd0);

      // T6: reset mid-word discards the partial bit
      do_reset(1);
      en2  = 1'b1;
      ser2 = 1'b1;
      step();
      step();
      check("t6_pre_word", {30'd0, par2}, 32'd3);
      ser2 = 1'b0;
      step();
      rst = 1'b1;
      step();
      check("t6_rst_par", {30'd0, par2}, 32'd0);
      check("t6_rst_valid", {31'd0, val2}, 32'd0);
      check("t6_rst_locked", {31'd0, lock2}, 32'd0);
      rst  = 1'b0;
      ser2 = 1'b0;
      step();
      check("t6_first_bit_valid", {31'd0, val2}, 32'd0);
      ser2 = 1'b1;
      step();
      check("t6_realign_valid", {31'd0, val2}, 32'd1);
      check("t6_realign_par", {30'd0, par2}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
